thumb_fetch_queue: RTL and testbench

- Instruction fetch front end that produces the ir_q0/ir_q1 halfword stream consumed by inst_decoder.
- Fetches aligned 32-bit words from instruction memory and splits them into Thumb halfwords in a small queue.
- Recognises 32-bit Thumb-2 encodings (first halfword [15:11] = 11101/11110/11111) and presents both halfwords together.
- Tracks the PC of each presented instruction and flushes/redirects on branch.

---
 rtl/thumb_fetch_queue.sv | 125 ++++++++++++
 tb/tb_thumb_fetch_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue
// Instruction fetch front end for the Thumb decoder. Aligned 32-bit words are
// fetched from instruction memory and split into halfwords in a small queue.
// The head instruction is presented as one halfword (16-bit encoding) or as
// two halfwords together (32-bit Thumb-2 encoding), along with its PC.
// A branch flushes the queue and restarts fetching at the new target.
module thumb_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [15:0] ir_q0,
  output logic [15:0] ir_q1,
  output logic        ir_is32,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   queue      [DEPTH];
  logic [15:0]   queue_next [DEPTH];
  logic [15:0]   queue_ext  [DEPTH + 2];
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   count32;
  logic [31:0]   base;
  logic [31:0]   fetch_addr;
  logic [31:0]   head_pc;
  logic          drop_low;
  logic          head_is32;
  logic          xfer;
  logic          pop;
  logic [1:0]    popn;
  logic [1:0]    pushn;
  logic [15:0]   push_hw0;
  logic          unused_target_bit;

  // Bit 0 of a branch target carries no address information for halfword code.
  assign unused_target_bit = branch_target[0];

  // Head decode, request generation and transfer/pop bookkeeping.
  assign count32   = 32'(count);
  assign head_is32 = (queue[0][15:13] == 3'b111) && (queue[0][12:11] != 2'b00);
  assign imem_req  = !rst && !branch_valid && (count32 <= 32'(DEPTH - 2));
  assign imem_addr = fetch_addr;
  assign ir_valid  = !rst && !branch_valid &&
                     ((count32 >= 32'd2) || ((count32 == 32'd1) && !head_is32));
  assign xfer      = imem_req && imem_ack;
  assign pop       = ir_valid && ir_ready;
  assign popn      = !pop ? 2'd0 : (head_is32 ? 2'd2 : 2'd1);
  assign pushn     = !xfer ? 2'd0 : (drop_low ? 2'd1 : 2'd2);
  assign push_hw0  = drop_low ? imem_rdata[31:16] : imem_rdata[15:0];
  assign base      = count32 - 32'(popn);
  assign count_next = count + CW'(pushn) - CW'(popn);

  // Presented instruction: fields are zeroed whenever nothing is presentable.
  assign ir_q0   = ir_valid ? queue[0] : 16'h0000;
  assign ir_q1   = (ir_valid && head_is32) ? queue[1] : 16'h0000;
  assign ir_is32 = ir_valid && head_is32;
  assign ir_pc   = head_pc;

  // Queue padded with two empty slots so the pop shift never indexes out of range.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      queue_ext[i] = queue[i];
    end
    queue_ext[DEPTH]     = 16'h0000;
    queue_ext[DEPTH + 1] = 16'h0000;
  end

  // Next queue image: shift out popped halfwords, then append pushed ones behind the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      case (popn)
        2'd1:    queue_next[i] = queue_ext[i + 1];
        2'd2:    queue_next[i] = queue_ext[i + 2];
        default: queue_next[i] = queue[i];
      endcase
      if ((pushn != 2'd0) && (32'(i) == base)) begin
        queue_next[i] = push_hw0;
      end
      if ((pushn == 2'd2) && (32'(i) == base + 32'd1)) begin
        queue_next[i] = imem_rdata[31:16];
      end
    end
  end

  // State update; a branch overrides any transfer or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      fetch_addr <= {RESET_PC[31:2], 2'b00};
      head_pc    <= {RESET_PC[31:1], 1'b0};
      drop_low   <= RESET_PC[1];
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= 16'h0000;
      end
    end else if (branch_valid) begin
      count      <= '0;
      fetch_addr <= {branch_target[31:2], 2'b00};
      head_pc    <= {branch_target[31:1], 1'b0};
      drop_low   <= branch_target[1];
    end else begin
      count   <= count_next;
      head_pc <= head_pc + {29'b0, popn, 1'b0};
      if (xfer) begin
        fetch_addr <= fetch_addr + 32'd4;
        drop_low   <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= queue_next[i];
      end
    end
  end

endmodule

// File: tb/tb_thumb_fetch_queue.sv
// tb_thumb_fetch_queue
// Self-checking bench for thumb_fetch_queue. A halfword-queue reference model
// tracks the expected fetch address, head PC and presented instruction.
module tb_thumb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [15:0] ir_q0;
  logic [15:0] ir_q1;
  logic        ir_is32;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  thumb_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .ir_q0(ir_q0), .ir_q1(ir_q1), .ir_is32(ir_is32), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents, filled randomly on first touch unless preset.
  logic [31:0] mem [logic [31:0]];

  // Reference model state.
  logic [15:0] m_q [$];
  logic [31:0] m_fa;
  logic [31:0] m_pc;
  logic        m_drop;

  // Expectations for the current cycle and the inputs that produced them.
  logic        exp_req, exp_valid, exp_is32;
  logic [31:0] exp_addr, exp_pc;
  logic [15:0] exp_q0, exp_q1;
  logic        st_bv, st_ack, st_ready;
  logic [31:0] st_bt, st_rdata;

  logic [63:0] seen [$];
  int checks;
  int errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [98:0] got_vec();
    return {imem_req, imem_addr, ir_valid, ir_q0, ir_q1, ir_is32, ir_pc};
  endfunction

  function automatic logic [98:0] exp_vec();
    return {exp_req, exp_addr, exp_valid, exp_q0, exp_q1, exp_is32, exp_pc};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_fa   = {RESET_PC[31:2], 2'b00};
    m_pc   = {RESET_PC[31:1], 1'b0};
    m_drop = RESET_PC[1];
  endfunction

  // Apply one cycle of inputs (caller sits at a negedge) and derive expected outputs.
  task automatic drive(input logic bv, input logic [31:0] bt, input logic ack, input logic rdy);
    int sz;
    logic h32;
    branch_valid  = bv;
    branch_target = bt;
    imem_ack      = ack;
    ir_ready      = rdy;
    imem_rdata    = mem_word(m_fa);
    st_bv = bv; st_bt = bt; st_ack = ack; st_ready = rdy; st_rdata = imem_rdata;
    sz  = m_q.size();
    h32 = (sz > 0) && (m_q[0][15:11] >= 5'b11101);
    exp_req   = !bv && (sz <= DEPTH - 2);
    exp_addr  = m_fa;
    exp_valid = !bv && ((sz >= 2) || (sz == 1 && !h32));
    exp_is32  = exp_valid && h32;
    exp_q0    = exp_valid ? m_q[0] : 16'h0000;
    exp_q1    = exp_is32 ? m_q[1] : 16'h0000;
    exp_pc    = m_pc;
    #1;
  endtask

  // Clock edge: advance the model with the decisions of the current cycle.
  task automatic tick();
    @(posedge clk);
    if (st_bv) begin
      m_q.delete();
      m_fa   = {st_bt[31:2], 2'b00};
      m_pc   = {st_bt[31:1], 1'b0};
      m_drop = st_bt[1];
    end else begin
      if (exp_valid && st_ready) begin
        void'(m_q.pop_front());
        if (exp_is32) void'(m_q.pop_front());
        m_pc = m_pc + (exp_is32 ? 32'd4 : 32'd2);
      end
      if (exp_req && st_ack) begin
        if (m_drop) begin
          m_q.push_back(st_rdata[31:16]);
          m_drop = 1'b0;
        end else begin
          m_q.push_back(st_rdata[15:0]);
          m_q.push_back(st_rdata[31:16]);
        end
        m_fa = m_fa + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    branch_valid = 1'b0; branch_target = '0; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    if (got_vec() !== {1'b0, {RESET_PC[31:2], 2'b00}, 1'b0, 16'h0, 16'h0, 1'b0, {RESET_PC[31:1], 1'b0}}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got=%h expected=%h", got_vec(),
               {1'b0, {RESET_PC[31:2], 2'b00}, 1'b0, 16'h0, 16'h0, 1'b0, {RESET_PC[31:1], 1'b0}});
    end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [63:0] want [5];
    mem[32'h0] = 32'h2105_2001;
    mem[32'h4] = 32'hF000_4770;
    mem[32'h8] = 32'h2300_F800;
    want[0] = {16'h2001, 16'h0000, 32'h0};
    want[1] = {16'h2105, 16'h0000, 32'h2};
    want[2] = {16'h4770, 16'h0000, 32'h4};
    want[3] = {16'hF000, 16'hF800, 32'h6};
    want[4] = {16'h2300, 16'h0000, 32'hA};
    seen.delete();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 32'h0, (c != 3), (c != 0));
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL stream_c%0d: got=%h expected=%h", c, got_vec(), exp_vec());
      end
      checks++;
      if (c == 4) begin
        if (ir_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL straddle_wait: ir_valid=%b expected 0", ir_valid);
        end
        checks++;
      end
      if (ir_valid && ir_ready) seen.push_back({ir_q0, ir_q1, ir_pc});
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      if (k >= seen.size() || seen[k] !== want[k]) begin
        errors++;
        $display("[TB] FAIL stream_order%0d: got=%h expected=%h", k,
                 (k < seen.size()) ? seen[k] : 64'h0, want[k]);
      end
      checks++;
    end
  endtask

  task automatic test_full();
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL full_fill_c%0d: got=%h expected=%h", c, got_vec(), exp_vec());
      end
      checks++;
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_req_low: imem_req=%b expected 0", imem_req);
    end
    checks++;
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL full_drain_c%0d: got=%h expected=%h", c, got_vec(), exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_branch();
    mem[32'h100] = 32'hBEEF_1234;
    drive(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    if (ir_valid !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL branch_cycle: got=%h expected=%h", got_vec(), exp_vec());
    end
    checks++;
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL branch_addr: req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr);
    end
    checks++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    if (ir_valid !== 1'b1 || ir_q0 !== 16'hBEEF || ir_pc !== 32'h102 || got_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL branch_head: got=%h expected=%h", got_vec(), exp_vec());
    end
    checks++;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [15:0] want [4];
    mem[32'h300] = 32'h2002_2001;
    mem[32'h304] = 32'h2004_2003;
    want[0] = 16'h2001; want[1] = 16'h2002; want[2] = 16'h2003; want[3] = 16'h2004;
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, (c == 0), 1'b1);
      if (ir_q0 !== want[c] || got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL simul_c%0d: got=%h expected=%h q0 want %h", c, got_vec(), exp_vec(), want[c]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic bv;
      bv = ($urandom_range(0, 19) == 0);
      drive(bv, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6));
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_c%0d: got=%h expected=%h", c, got_vec(), exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    mem[32'h400] = 32'h2002_2001;
    drive(1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    if (ir_valid !== 1'b1 || imem_req !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL areset_pre: got=%h expected=%h", got_vec(), exp_vec());
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir_q0 !== 16'h0 || ir_pc !== {RESET_PC[31:1], 1'b0}) begin
      errors++;
      $display("[TB] FAIL areset_mid: req=%b valid=%b q0=%h pc=%h expected 0 0 0000 %h",
               imem_req, ir_valid, ir_q0, ir_pc, {RESET_PC[31:1], 1'b0});
    end
    checks++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    if (imem_addr !== {RESET_PC[31:2], 2'b00} || got_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL areset_post: got=%h expected=%h", got_vec(), exp_vec());
    end
    checks++;
    tick();
  endtask

  // Run every scenario in turn, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_full();
    test_branch();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
